// File: rtl/clock_display_pkg.sv
// Shared types and seven-segment constants for the clock display driver.
package clock_display_pkg;

    localparam int unsigned BIN_W = 6;
    localparam int unsigned BCD_W = 8;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_LOAD,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_e;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin6_to_bcd.sv
// Sequential 6-bit binary to 2-digit BCD converter (shift-add-3), one bit per cycle.
module bin6_to_bcd
    import clock_display_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic             done_c_o
);

    conv_state_e      state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] acc_q, acc_d;
    logic [BCD_W-1:0] adj_c;
    logic [2:0]       cnt_q, cnt_d;
    logic             load_c;
    logic             shift_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CONV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CONV_IDLE:  if (start_i) state_d = CONV_LOAD;
            CONV_LOAD:  state_d = CONV_SHIFT;
            CONV_SHIFT: if (cnt_q == 3'(BIN_W - 1)) state_d = CONV_DONE;
            CONV_DONE:  state_d = CONV_IDLE;
            default:    state_d = CONV_IDLE;
        endcase
    end

    always_comb begin
        load_c   = 1'b0;
        shift_c  = 1'b0;
        done_c_o = 1'b0;
        case (state_q)
            CONV_LOAD:  load_c   = 1'b1;
            CONV_SHIFT: shift_c  = 1'b1;
            CONV_DONE:  done_c_o = 1'b1;
            default:    ;
        endcase
    end

    // Correct each BCD nibble before the shift so it carries properly into the next digit.
    always_comb begin
        adj_c = acc_q;
        if (adj_c[3:0] >= 4'd5) adj_c[3:0] = adj_c[3:0] + 4'd3;
        if (adj_c[7:4] >= 4'd5) adj_c[7:4] = adj_c[7:4] + 4'd3;

        bin_d = bin_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load_c) begin
            bin_d = bin_i;
            acc_d = '0;
            cnt_d = '0;
        end else if (shift_c) begin
            acc_d = {adj_c[6:0], bin_q[BIN_W-1]};
            bin_d = {bin_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign bcd_o = acc_q;

endmodule

// File: rtl/clock_display_driver.sv
// Multiplexed 4-digit common-anode display of HH:MM or MM:SS, snapshotted once per frame.
module clock_display_driver
    import clock_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       show_seconds,
    input  logic       colon_en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int unsigned   TICK_W    = $clog2(SCAN_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]        digit_idx_q, digit_idx_d;
    logic [BIN_W-1:0]  upper_stage_q, upper_stage_d;
    logic [BIN_W-1:0]  lower_stage_q, lower_stage_d;
    logic              colon_stage_q, colon_stage_d;
    logic [15:0]       result_bcd_q, result_bcd_d;
    logic              result_dp_q, result_dp_d;
    logic [15:0]       disp_bcd_q, disp_bcd_d;
    logic              disp_dp_q, disp_dp_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        an_q, an_d;

    logic              tick_wrap_c;
    logic              snap_c;
    logic              commit_c;
    logic [3:0]        nibble_c;
    logic [BCD_W-1:0]  upper_bcd_c, lower_bcd_c;
    logic              upper_done_c, lower_done_c;

    bin6_to_bcd u_conv_upper (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (snap_c),
        .bin_i    (upper_stage_q),
        .bcd_o    (upper_bcd_c),
        .done_c_o (upper_done_c)
    );

    bin6_to_bcd u_conv_lower (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (snap_c),
        .bin_i    (lower_stage_q),
        .bcd_o    (lower_bcd_c),
        .done_c_o (lower_done_c)
    );

    assign tick_wrap_c = (tick_cnt_q == TICK_LAST);
    assign snap_c      = (digit_idx_q == 2'd3) && (tick_cnt_q == '0);
    assign commit_c    = (digit_idx_q == 2'd3) && tick_wrap_c;

    always_comb begin
        case (digit_idx_q)
            2'd0:    nibble_c = disp_bcd_q[3:0];
            2'd1:    nibble_c = disp_bcd_q[7:4];
            2'd2:    nibble_c = disp_bcd_q[11:8];
            default: nibble_c = disp_bcd_q[15:12];
        endcase
    end

    always_comb begin
        tick_cnt_d    = tick_wrap_c ? '0 : tick_cnt_q + TICK_W'(1);
        digit_idx_d   = tick_wrap_c ? digit_idx_q + 2'd1 : digit_idx_q;
        upper_stage_d = upper_stage_q;
        lower_stage_d = lower_stage_q;
        colon_stage_d = colon_stage_q;
        result_bcd_d  = result_bcd_q;
        result_dp_d   = result_dp_q;
        disp_bcd_d    = disp_bcd_q;
        disp_dp_d     = disp_dp_q;

        if (snap_c) begin
            upper_stage_d = show_seconds ? minutes : {1'b0, hours};
            lower_stage_d = show_seconds ? seconds : minutes;
            colon_stage_d = colon_en;
        end
        if (upper_done_c && lower_done_c) begin
            result_bcd_d = {upper_bcd_c, lower_bcd_c};
            result_dp_d  = colon_stage_q;
        end
        // Display registers only move on the frame boundary, so a frame never tears.
        if (commit_c) begin
            disp_bcd_d = result_bcd_q;
            disp_dp_d  = result_dp_q;
        end

        an_d  = ~(4'b0001 << digit_idx_q);
        seg_d = bcd_to_seg(nibble_c);
        dp_d  = ~(disp_dp_q && (digit_idx_q == 2'd2));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q    <= '0;
            digit_idx_q   <= '0;
            upper_stage_q <= '0;
            lower_stage_q <= '0;
            colon_stage_q <= 1'b0;
            result_bcd_q  <= '0;
            result_dp_q   <= 1'b0;
            disp_bcd_q    <= '0;
            disp_dp_q     <= 1'b0;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            an_q          <= 4'hF;
        end else begin
            tick_cnt_q    <= tick_cnt_d;
            digit_idx_q   <= digit_idx_d;
            upper_stage_q <= upper_stage_d;
            lower_stage_q <= lower_stage_d;
            colon_stage_q <= colon_stage_d;
            result_bcd_q  <= result_bcd_d;
            result_dp_q   <= result_dp_d;
            disp_bcd_q    <= disp_bcd_d;
            disp_dp_q     <= disp_dp_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// Bench for clock_display_driver: frame-level display model checked every cycle plus literal pins.
module tb_clock_display_driver;

    localparam int S     = 16;
    localparam int FRAME = 4 * S;

    logic       clk;
    logic       rst_n;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       show_seconds;
    logic       colon_en;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int tests;
    int fails;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Model: what the display must show, derived from cycles since reset and per-frame snapshots.
    bit         model_valid;
    int         cyc;
    int         shown [4];
    int         pend  [4];
    bit         shown_col;
    bit         pend_col;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    clock_display_driver #(.SCAN_DIV(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hours        (hours),
        .minutes      (minutes),
        .seconds      (seconds),
        .show_seconds (show_seconds),
        .colon_en     (colon_en),
        .seg          (seg),
        .dp           (dp),
        .an           (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_update();
        int n, dig, up, lo;
        if (!rst_n) begin
            model_valid = 1'b1;
            cyc         = 0;
            for (int i = 0; i < 4; i++) begin
                shown[i] = 0;
                pend[i]  = 0;
            end
            shown_col = 1'b0;
            pend_col  = 1'b0;
            exp_an    = 4'hF;
            exp_seg   = 7'h7F;
            exp_dp    = 1'b1;
        end else if (model_valid) begin
            n   = cyc % FRAME;
            dig = n / S;
            if (n == 3 * S) begin
                up       = show_seconds ? int'(minutes) : int'(hours);
                lo       = show_seconds ? int'(seconds) : int'(minutes);
                pend[3]  = up / 10;
                pend[2]  = up % 10;
                pend[1]  = lo / 10;
                pend[0]  = lo % 10;
                pend_col = colon_en;
            end
            exp_an      = 4'hF;
            exp_an[dig] = 1'b0;
            exp_seg     = seg_tab[shown[dig]];
            exp_dp      = !(shown_col && dig == 2);
            if (n == FRAME - 1) begin
                shown     = pend;
                shown_col = pend_col;
            end
            cyc++;
        end
    endtask

    // One clock: advance the model at the edge, compare DUT against it on the falling edge.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (model_valid) begin
            chk("model_an", 16'(an), 16'(exp_an));
            chk("model_seg", 16'(seg), 16'(exp_seg));
            chk("model_dp", 16'(dp), 16'(exp_dp));
        end
    endtask

    task automatic wait_an(input logic [3:0] target);
        int k;
        k = 0;
        while (an !== target && k < 300) begin
            step();
            k++;
        end
        if (an !== target) begin
            tests++;
            fails++;
            $display("FAIL wait_an timeout: an=%b, expected %b", an, target);
        end
    endtask

    initial begin
        int len;
        tests        = 0;
        fails        = 0;
        model_valid  = 1'b0;
        rst_n        = 1'b0;
        hours        = '0;
        minutes      = '0;
        seconds      = '0;
        show_seconds = 1'b0;
        colon_en     = 1'b0;

        repeat (5) step();
        chk("reset_seg", 16'(seg), 16'h7F);
        chk("reset_an", 16'(an), 16'hF);
        chk("reset_dp", 16'(dp), 16'd1);

        // HH:MM 23:59 with colon
        hours    = 5'd23;
        minutes  = 6'd59;
        colon_en = 1'b1;
        rst_n    = 1'b1;
        step();
        chk("first_an", 16'(an), 16'(4'b1110));
        chk("first_seg", 16'(seg), 16'(7'b1000000));
        chk("first_dp", 16'(dp), 16'd1);
        repeat (70) step();
        wait_an(4'b1011);
        chk("hhmm_d2_seg", 16'(seg), 16'(7'b0110000));
        chk("hhmm_d2_dp", 16'(dp), 16'd0);
        wait_an(4'b0111);
        chk("hhmm_d3_seg", 16'(seg), 16'(7'b0100100));
        chk("hhmm_d3_dp", 16'(dp), 16'd1);
        wait_an(4'b1110);
        chk("hhmm_d0_seg", 16'(seg), 16'(7'b0010000));
        wait_an(4'b1101);
        chk("hhmm_d1_seg", 16'(seg), 16'(7'b0010010));

        // MM:SS 07:42
        show_seconds = 1'b1;
        minutes      = 6'd7;
        seconds      = 6'd42;
        colon_en     = 1'b0;
        repeat (140) step();
        wait_an(4'b0111);
        chk("mmss_d3_seg", 16'(seg), 16'(7'b1000000));
        wait_an(4'b1110);
        chk("mmss_d0_seg", 16'(seg), 16'(7'b0100100));
        len = 0;
        while (an === 4'b1110 && len < 100) begin
            len++;
            step();
        end
        chk("digit_dwell", 16'(len), 16'd16);
        chk("order_after_d0", 16'(an), 16'(4'b1101));
        chk("mmss_d1_seg", 16'(seg), 16'(7'b0011001));
        wait_an(4'b1011);
        chk("mmss_d2_seg", 16'(seg), 16'(7'b1111000));

        // Change before the snapshot: appears at the next frame
        wait_an(4'b1101);
        seconds = 6'd43;
        step();
        chk("tear_same_frame", 16'(seg), 16'(7'b0011001));
        wait_an(4'b1110);
        chk("tear_next_frame", 16'(seg), 16'(7'b0110000));
        // Change just after the snapshot: held off one more frame
        wait_an(4'b0111);
        seconds = 6'd44;
        wait_an(4'b1110);
        chk("tear_post_snap", 16'(seg), 16'(7'b0110000));
        wait_an(4'b0111);
        wait_an(4'b1110);
        chk("tear_later", 16'(seg), 16'(7'b0011001));

        // Out-of-range values shown verbatim
        minutes = 6'd63;
        seconds = 6'd0;
        repeat (140) step();
        wait_an(4'b0111);
        chk("oor_d3_seg", 16'(seg), 16'(7'b0000010));
        wait_an(4'b1110);
        chk("oor_d0_seg", 16'(seg), 16'(7'b1000000));
        wait_an(4'b1011);
        chk("oor_d2_seg", 16'(seg), 16'(7'b0110000));
        hours        = 5'd31;
        show_seconds = 1'b0;
        repeat (140) step();
        wait_an(4'b0111);
        chk("oor_hh_d3_seg", 16'(seg), 16'(7'b0110000));
        wait_an(4'b1011);
        chk("oor_hh_d2_seg", 16'(seg), 16'(7'b1111001));

        // Reset during the third shift cycle of a 12:34 conversion
        hours   = 5'd12;
        minutes = 6'd34;
        wait_an(4'b0111);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("midrst_an", 16'(an), 16'hF);
        rst_n = 1'b1;
        step();
        chk("midrst_first_seg", 16'(seg), 16'(7'b1000000));
        wait_an(4'b0111);
        chk("midrst_frame0_d3", 16'(seg), 16'(7'b1000000));
        wait_an(4'b1110);
        chk("midrst_frame1_d0", 16'(seg), 16'(7'b0011001));
        wait_an(4'b0111);
        chk("midrst_frame1_d3", 16'(seg), 16'(7'b1111001));
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_display_driver.md
# clock_display_driver

Downstream consumer of the binary clock core. Takes the live `Hours`/`Minutes`/`Seconds` values and drives a 4-digit, common-anode, multiplexed 7-segment display. It shows either HH:MM or MM:SS, lit with a colon decimal point. Binary-to-BCD conversion is a sequential shift-add-3 engine. Inputs are snapshotted once per display frame, so no digit ever tears mid-frame.

## Interface
- `SCAN_DIV`, default 50000: clk cycles each digit stays lit (1 kHz digit rate at 50 MHz). Legal range is ≥16.
- `clk` input, 1 bit: the single system clock.
- `rst_n` input, 1 bit: synchronous, active-low reset, sampled on the `clk` rising edge.
- `hours` input, 5 bits: binary hours, 0..23 nominal.
- `minutes` input, 6 bits: binary minutes, 0..59 nominal.
- `seconds` input, 6 bits: binary seconds, 0..59 nominal.
- `show_seconds` input, 1 bit: 0 selects HH:MM, 1 selects MM:SS. Sampled at snapshot.
- `colon_en` input, 1 bit: 1 lights the dp on digit 2. Sampled at snapshot.
- `seg` output, 7 bits: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp` output, 1 bit: decimal point, active-low.
- `an` output, 4 bits: digit anodes, active-low. `an[0]` is the rightmost digit.

## Operation
- **Scan counter:** `tick_cnt` counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and advances `digit_idx` (2 bits) 0→1→2→3→0.
- **Field select:** upper = `show_seconds ? minutes : {1'b0,hours}`; lower = `show_seconds ? seconds : minutes`.
- **Snapshot:** when `digit_idx==3 && tick_cnt==0`, both 6-bit fields plus `colon_en` are captured into staging, and the converter starts.
- **Converter FSM** (both fields converted in parallel):
  - IDLE: wait for snapshot.
  - LOAD (1 cycle): clear the 8-bit BCD accumulators and load the binary shift registers.
  - SHIFT (6 cycles): each cycle, add 3 to any BCD nibble ≥5, then shift left one bit from the binary register.
  - DONE (1 cycle): write `result_bcd` (16 bits) and `result_dp`, then return to IDLE.
  - Total 8 cycles from snapshot, always complete before the frame wraps because SCAN_DIV ≥ 16.
- **Frame commit:** on the 3→0 wrap of `digit_idx`, `disp_bcd` ← `result_bcd` and `disp_dp` ← `result_dp`. Display registers change only here.
- **Digit mapping:**
  - digit 3 = upper tens
  - digit 2 = upper ones, carries the dp when `disp_dp`
  - digit 1 = lower tens
  - digit 0 = lower ones
- **Out-of-range input** (e.g. minutes=63, hours=31): converted faithfully to BCD and shown as "63" / "31". No clamping.
- **Segment decode:**
  - BCD 0..9 use the standard patterns: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000.
  - Nibble values 10..15 (unreachable) decode to 7'b1111111, blank.
- **Reset** (`rst_n` low at a clk edge):
  - outputs: `seg`=7'h7F, `dp`=1, `an`=4'hF
  - counters: `tick_cnt`=0, `digit_idx`=0
  - FSM returns to IDLE
  - data registers: `disp_bcd`, `result_bcd`, `disp_dp`, `result_dp` = 0
- **Mid-conversion reset:** a reset during conversion aborts it. No partial result is ever committed.

## Timing
- `an`, `seg` and `dp` are registered. Each changes exactly 1 cycle after `digit_idx` changes.
- First cycle after reset release: `an`=4'b1110, `seg`=7'b1000000 (digit "0"), `dp`=1. The display shows 00:00 until the first commit.
- First snapshot comes at cycle 3·SCAN_DIV after reset release. The first commit is at 4·SCAN_DIV, visible 1 cycle later.
- Input-to-display latency ranges from 1·SCAN_DIV+1 to 5·SCAN_DIV+1 cycles, depending on the frame phase.
- Input changes that occur between snapshots are invisible until the next snapshot.
- `show_seconds` toggling mid-frame takes effect only at the next snapshot. No mixed HH:SS frame is possible.

## Structure
- **Package `clock_display_pkg`:**
  - converter state enum (IDLE, LOAD, SHIFT, DONE)
  - `SEG_BLANK` = 7'h7F
  - the ten segment-pattern constants and a `bcd_to_seg` function
- **Sub-module `bin6_to_bcd`:** sequential 6-bit shift-add-3 converter with `start`/`done`. The top instantiates two of them, or one with a 12-bit datapath.
- The top holds the scan counter, snapshot/commit registers and output registers.

## Test plan
All scenarios use SCAN_DIV=16.
- **Reset:** hold `rst_n`=0 for 5 cycles → `seg`=7'h7F, `an`=4'hF, `dp`=1. After release, the next cycle shows `an`=4'b1110, `seg`=7'b1000000.
- **HH:MM display:** hours=23, minutes=59, show_seconds=0, colon_en=1 → after commit, digits 3..0 show 2,3,5,9. `dp`=0 only while `an`=4'b1011.
- **MM:SS display:** show_seconds=1, minutes=7, seconds=42 → digits read 0,7,4,2. Each digit is lit for exactly 16 cycles, in an order that cycles 1110→1101→1011→0111.
- **Tearing:** change `seconds` from 42 to 43 at `digit_idx`=1 → the current frame still shows 42; the next frame after the following snapshot shows 43.
- **Out-of-range:** minutes=63, seconds=0, show_seconds=1 → digits 3..0 show 6,3,0,0.
- **Reset mid-conversion:** assert `rst_n`=0 for 1 cycle in the 3rd SHIFT cycle → FSM is IDLE, `disp_bcd` stays 0, and the display shows 00:00 on the following frame.
